// File: rtl/lzy_sipo_rx.sv
// lzy_sipo_rx: serial-in parallel-out frame receiver with valid/pend/overrun handshake
module lzy_sipo_rx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Ds,
    input  logic             CE,
    input  logic             Sync,
    input  logic             Ack,
    output logic [WIDTH-1:0] Q,
    output logic             Valid,
    output logic             Pend,
    output logic             Busy,
    output logic             Ovf
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d, q_q, q_d, shift_w;
    logic             valid_q, pend_q, pend_d, ovf_q, ovf_d, samp_w, done_w;
    always_comb begin
        shift_w = MSB_FIRST ? {sr_q[WIDTH-2:0], Ds} : {Ds, sr_q[WIDTH-1:1]};
        samp_w  = !Sync && !CE;
        done_w  = samp_w && state_q == SHIFT && cnt_q == CW'(WIDTH-1);
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        q_d     = done_w ? shift_w : q_q;
        pend_d  = done_w ? 1'b1 : (Ack ? 1'b0 : pend_q);
        ovf_d   = ovf_q || (done_w && pend_q && !Ack);
        if (Sync) begin
            state_d = IDLE;
            cnt_d   = '0;
            sr_d    = '0;
        end else if (samp_w) begin
            sr_d    = shift_w;
            cnt_d   = done_w ? '0 : cnt_q + 1'b1;
            state_d = done_w ? IDLE : SHIFT;
        end
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            q_q     <= q_d;
            valid_q <= done_w;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end
    assign Q     = q_q;
    assign Valid = valid_q;
    assign Pend  = pend_q;
    assign Busy  = state_q == SHIFT;
    assign Ovf   = ovf_q;
endmodule

// File: tb/tb_lzy_sipo_rx.sv
// tb_lzy_sipo_rx: random and directed checks of lzy_sipo_rx (both bit orders) against a queue-based model
module tb_lzy_sipo_rx;
    localparam int W = 8;
    logic Clk = 0, Reset_n = 1, Ds = 0, CE = 1, Sync = 0, Ack = 0;
    logic [W-1:0] q1, q0;
    logic v1, p1, b1, o1, v0, p0, b0, o0;
    int n_tests = 0, n_fail = 0;
    bit m_bits[$];
    logic [W-1:0] m_q1 = '0, m_q0 = '0;
    bit m_v = 0, m_p = 0, m_o = 0;

    lzy_sipo_rx #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
        .Clk(Clk), .Reset_n(Reset_n), .Ds(Ds), .CE(CE), .Sync(Sync), .Ack(Ack),
        .Q(q1), .Valid(v1), .Pend(p1), .Busy(b1), .Ovf(o1));
    lzy_sipo_rx #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
        .Clk(Clk), .Reset_n(Reset_n), .Ds(Ds), .CE(CE), .Sync(Sync), .Ack(Ack),
        .Q(q0), .Valid(v0), .Pend(p0), .Busy(b0), .Ovf(o0));

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit busy = m_bits.size() != 0;
        check({tag, ".q_msb"}, 32'(q1), 32'(m_q1));
        check({tag, ".q_lsb"}, 32'(q0), 32'(m_q0));
        check({tag, ".valid"}, {30'd0, v1, v0}, {30'd0, m_v, m_v});
        check({tag, ".pend"}, {30'd0, p1, p0}, {30'd0, m_p, m_p});
        check({tag, ".busy"}, {30'd0, b1, b0}, {30'd0, busy, busy});
        check({tag, ".ovf"}, {30'd0, o1, o0}, {30'd0, m_o, m_o});
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_q1 = '0; m_q0 = '0; m_v = 0; m_p = 0; m_o = 0;
    endtask

    task automatic cyc(input bit d, input bit c, input bit s, input bit a);
        bit done = 0;
        Ds = d; CE = c; Sync = s; Ack = a;
        @(posedge Clk);
        if (s) m_bits.delete();
        else if (!c) begin
            m_bits.push_back(d);
            if (m_bits.size() == W) begin
                done = 1;
                for (int i = 0; i < W; i++) begin
                    m_q1 = m_q1 * 2 + W'(m_bits[i]);
                    m_q0[i] = m_bits[i];
                end
                m_bits.delete();
            end
        end
        m_v = done;
        if (done) begin
            m_o = m_o | (m_p & !a);
            m_p = 1;
        end else if (a) m_p = 0;
        #1 check_all("cyc");
    endtask

    task automatic pulse_reset();
        Reset_n = 0;
        #2;
        model_reset();
        check_all("rst");
        #1 Reset_n = 1;
    endtask

    task automatic send(input logic [W-1:0] w, input bit ack_last);
        for (int i = W - 1; i >= 0; i--) cyc(w[i], 0, 0, ack_last && i == 0);
    endtask

    initial begin
        #1 Reset_n = 0;
        #2;
        model_reset();
        check_all("por");
        @(posedge Clk);
        #1 Reset_n = 1;
        send(8'hB2, 0);
        check("b2_q_msb", 32'(q1), 32'h B2);
        check("b2_q_lsb", 32'(q0), 32'h4D);
        check("b2_vpbo", {28'd0, v1, p1, b1, o1}, 32'b1100);
        cyc(0, 1, 0, 1);
        check("ack_pend", {30'd0, p1, o1}, 32'd0);
        for (int i = W - 1; i >= 0; i--) begin
            cyc(8'hA5 >> i, 0, 0, 0);
            if (i == 5) repeat (5) cyc(1, 1, 0, 0);
        end
        check("a5_q", 32'(q1), 32'hA5);
        cyc(0, 1, 0, 1);
        send(8'h3C, 0);
        send(8'hC3, 0);
        check("ovr", {23'd0, q1, o1}, {23'd0, 8'hC3, 1'b1});
        pulse_reset();
        send(8'h3C, 0);
        send(8'hC3, 1);
        check("ack_on_done", {30'd0, p1, o1}, 32'b10);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        send(8'h81, 1);
        check("sync_81", 32'(q1), 32'h81);
        for (int i = 0; i < 5; i++) cyc(i[0], 0, 0, 0);
        pulse_reset();
        send(8'h5A, 0);
        check("rst_5a", 32'(q1), 32'h5A);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) pulse_reset();
            else cyc(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                     $urandom_range(0, 24) == 0, $urandom_range(0, 4) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
